// File: rtl/imem_sync_loader.sv
// imem_sync_loader: synchronous instruction memory with a registered 1-cycle
// fetch port and a streaming program-load port for (re)writing the image at runtime.
// Sits between the PC register and the decoder; a boot controller or testbench
// drives the load port. Program images are written through the load port.
//
// Optional feature macro: IMEM_PARITY_EN
//   defined   -> array is IW+1 wide, MSB holds even parity over the stored word;
//                a fetch that sees a mismatch returns HALT_WORD with parity_err=1.
//   undefined -> array is IW wide, parity_err is always 0.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   fetch_req, PC           fetch request and address (honoured only in IDLE)
//   inst, inst_valid        registered instruction and 1-cycle valid pulse
//   oob, parity_err         qualify inst_valid: out-of-range PC / stored parity error
//   ld_start, ld_base       begin a burst at ld_base
//   ld_valid, ld_data       word to write; ld_last marks the final word
//   ld_ready                high while in LOAD
//   ld_count                words written in current/last burst, saturates at 2**AW
module imem_sync_loader #(
  parameter int unsigned     IW        = 9,
  parameter int unsigned     AW        = 10,
  parameter int unsigned     PCW       = 16,
  parameter logic [IW-1:0]   HALT_WORD = {IW{1'b1}}
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           fetch_req,
  input  logic [PCW-1:0] PC,
  output logic [IW-1:0]  inst,
  output logic           inst_valid,
  output logic           oob,
  input  logic           ld_start,
  input  logic [AW-1:0]  ld_base,
  input  logic           ld_valid,
  input  logic [IW-1:0]  ld_data,
  input  logic           ld_last,
  output logic           ld_ready,
  output logic [AW:0]    ld_count,
  output logic           parity_err
);

  localparam int unsigned DEPTH = 2**AW;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MW = IW + 1;
`else
  localparam int unsigned MW = IW;
`endif
  localparam logic [PCW:0] PC_LIMIT = (PCW+1)'(DEPTH);
  localparam logic [AW:0]  CNT_MAX  = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   wr_ptr;
  logic            fetch_go;
  logic            wr_en;
  logic            ld_entry;
  logic            pc_oob;
  logic            rd_perr;
  logic [MW-1:0]   wr_word;
  logic [MW-1:0]   rd_word;
  logic [MW-1:0]   mem [DEPTH];

  // Address range check done at PCW+1 bits so PCW == AW never flags.
  assign pc_oob  = ((PCW+1)'(PC) >= PC_LIMIT);
  assign rd_word = mem[PC[AW-1:0]];

`ifdef IMEM_PARITY_EN
  // Stored MSB makes total parity even; any odd XOR over the entry is an error.
  assign wr_word = {^ld_data, ld_data};
  assign rd_perr = ^rd_word;
`else
  assign wr_word = ld_data;
  assign rd_perr = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (ld_start)            state_next = S_LOAD;
      S_LOAD: if (ld_valid && ld_last) state_next = S_IDLE;
      default:                         state_next = S_IDLE;
    endcase
  end

  // Control decode: load start beats a same-cycle fetch.
  always_comb begin
    fetch_go = 1'b0;
    wr_en    = 1'b0;
    ld_entry = 1'b0;
    case (state)
      S_IDLE: begin
        ld_entry = ld_start;
        fetch_go = fetch_req && !ld_start;
      end
      S_LOAD: wr_en = ld_valid;
      default: ;
    endcase
  end

  // Registered outputs and load pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst       <= HALT_WORD;
      inst_valid <= 1'b0;
      oob        <= 1'b0;
      parity_err <= 1'b0;
      ld_ready   <= 1'b0;
      ld_count   <= '0;
      wr_ptr     <= '0;
    end else begin
      ld_ready   <= (state_next == S_LOAD);
      inst_valid <= fetch_go;
      oob        <= 1'b0;
      parity_err <= 1'b0;
      if (fetch_go) begin
        if (pc_oob) begin
          inst <= HALT_WORD;
          oob  <= 1'b1;
        end else if (rd_perr) begin
          inst       <= HALT_WORD;
          parity_err <= 1'b1;
        end else begin
          inst <= rd_word[IW-1:0];
        end
      end
      if (ld_entry) begin
        wr_ptr   <= ld_base;
        ld_count <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (ld_count != CNT_MAX) ld_count <= ld_count + (AW+1)'(1);
      end
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

endmodule

// File: tb/tb_imem_sync_loader.sv
// Self-checking bench for imem_sync_loader (default parameters).
module tb_imem_sync_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] PC = '0;
  logic [8:0]  inst;
  logic        inst_valid;
  logic        oob;
  logic        ld_start = 1'b0;
  logic [9:0]  ld_base = '0;
  logic        ld_valid = 1'b0;
  logic [8:0]  ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [10:0] ld_count;
  logic        parity_err;

  int errors = 0;
  int checks = 0;
  int flip_addr = -1;

  logic [8:0] bw [0:1100];

  imem_sync_loader dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .PC(PC),
    .inst(inst), .inst_valid(inst_valid), .oob(oob),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_count(ld_count), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory image plus what the outputs must show.
  logic [8:0] m_mem [1024];
  logic       m_load = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_oob = 1'b0;
  logic       m_perr = 1'b0;
  logic [8:0] m_inst = 9'h1FF;
  int         m_ptr = 0;
  int         m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_load  <= 1'b0;
      m_valid <= 1'b0;
      m_oob   <= 1'b0;
      m_perr  <= 1'b0;
      m_inst  <= 9'h1FF;
      m_ptr   <= 0;
      m_cnt   <= 0;
    end else if (!m_load) begin
      m_valid <= 1'b0;
      m_oob   <= 1'b0;
      m_perr  <= 1'b0;
      if (ld_start) begin
        m_load <= 1'b1;
        m_ptr  <= ld_base;
        m_cnt  <= 0;
      end else if (fetch_req) begin
        m_valid <= 1'b1;
        if (PC >= 16'd1024) begin
          m_inst <= 9'h1FF;
          m_oob  <= 1'b1;
        end else if (int'(PC) == flip_addr) begin
          m_inst <= 9'h1FF;
          m_perr <= 1'b1;
        end else begin
          m_inst <= m_mem[PC[9:0]];
        end
      end
    end else begin
      m_valid <= 1'b0;
      if (ld_valid) begin
        m_mem[m_ptr] <= ld_data;
        m_ptr <= (m_ptr + 1) % 1024;
        m_cnt <= (m_cnt < 1024) ? m_cnt + 1 : 1024;
        if (ld_last) m_load <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ld_ready", 32'(ld_ready), 32'(m_load));
    chk("ld_count", 32'(ld_count), 32'(m_cnt));
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("inst", 32'(inst), 32'(m_inst));
    if (m_valid) begin
      chk("oob", 32'(oob), 32'(m_oob));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    fetch_req = 1'b0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
  endtask

  task automatic do_burst(input logic [9:0] base, input int n);
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = bw[i];
      ld_last  = (i == n - 1);
      tick();
    end
    idle_in();
  endtask

  task automatic fetch_chk(input logic [15:0] pc, input logic [8:0] exp);
    fetch_req = 1'b1;
    PC = pc;
    tick();
    chk("fetch_inst", 32'(inst), 32'(exp));
    chk("fetch_valid", 32'(inst_valid), 32'd1);
  endtask

  initial begin
    idle_in();
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Full-depth burst of 1025 words: wraps onto address 0, count saturates.
    for (int i = 0; i < 1025; i++) bw[i] = 9'($urandom);
    bw[1] = 9'h055;
    do_burst(10'd0, 1025);
    chk("sat_count", 32'(ld_count), 32'h400);
    fetch_chk(16'd0, bw[1024]);

    // Mid-cycle reset with a fetch pending.
    fetch_chk(16'd1, 9'h055);
    reset = 1'b1;
    #1;
    chk("rst_inst", 32'(inst), 32'h1FF);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    idle_in();
    tick();
    reset = 1'b0;
    tick();

    // Basic load then back-to-back fetches.
    bw[0] = 9'h041; bw[1] = 9'h0A2; bw[2] = 9'h1C3;
    do_burst(10'd0, 3);
    chk("t2_count", 32'(ld_count), 32'd3);
    chk("t2_ready", 32'(ld_ready), 32'd0);
    fetch_chk(16'd0, 9'h041);
    fetch_chk(16'd1, 9'h0A2);
    fetch_chk(16'd2, 9'h1C3);
    idle_in();
    tick();
    chk("t2_valid_drop", 32'(inst_valid), 32'd0);
    chk("t2_hold", 32'(inst), 32'h1C3);

    // Pointer wrap at the top of the array.
    bw[0] = 9'h0AA; bw[1] = 9'h0BB; bw[2] = 9'h0CC; bw[3] = 9'h0DD;
    do_burst(10'd1022, 4);
    chk("t3_count", 32'(ld_count), 32'd4);
    fetch_chk(16'd1022, 9'h0AA);
    fetch_chk(16'd1023, 9'h0BB);
    fetch_chk(16'd0, 9'h0CC);
    fetch_chk(16'd1, 9'h0DD);

    // Out-of-range fetch and load/fetch contention.
    fetch_chk(16'h0400, 9'h1FF);
    chk("t4_oob", 32'(oob), 32'd1);
    fetch_req = 1'b1;
    PC = 16'd2;
    ld_start = 1'b1;
    ld_base = 10'd7;
    tick();
    chk("t4_drop", 32'(inst_valid), 32'd0);
    chk("t4_ready", 32'(ld_ready), 32'd1);
    fetch_req = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 9'h123;
    ld_last = 1'b1;
    tick();
    idle_in();
    fetch_chk(16'd7, 9'h123);
    idle_in();

    // Reset after 2 of 4 words.
    bw[0] = 9'h111; bw[1] = 9'h122;
    ld_start = 1'b1;
    ld_base = 10'd100;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data = bw[i];
      tick();
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_count", 32'(ld_count), 32'd0);
    chk("t6_ready", 32'(ld_ready), 32'd0);
    fetch_chk(16'd100, 9'h111);
    fetch_chk(16'd101, 9'h122);
    idle_in();
    tick();

    // Randomised traffic: overlapping starts, gaps, idle ld_valid, rare resets.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      ld_start  = ($urandom_range(0, 99) < 4);
      ld_base   = 10'($urandom);
      fetch_req = 1'($urandom_range(0, 1));
      PC        = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
      ld_valid  = ($urandom_range(0, 2) != 0);
      ld_data   = 9'($urandom);
      ld_last   = ($urandom_range(0, 7) == 0);
      tick();
    end
    reset = 1'b0;
    idle_in();
    tick();
    // Close any open burst so the bench ends in IDLE.
    ld_valid = 1'b1;
    ld_last = 1'b1;
    ld_data = 9'h000;
    tick();
    idle_in();
    tick();

`ifdef IMEM_PARITY_EN
    for (int i = 0; i < 8; i++) bw[i] = 9'($urandom);
    do_burst(10'd0, 8);
    dut.mem[5][0] = ~dut.mem[5][0];
    flip_addr = 5;
    fetch_chk(16'd5, 9'h1FF);
    chk("t5_perr", 32'(parity_err), 32'd1);
    idle_in();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
